// File: rtl/chain_meter_pkg.sv
// Shared types and constants for the inverter-chain delay meter.
package chain_meter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    LAUNCH,
    MEASURE,
    DONE,
    FAIL
  } state_t;

  // Wide all-ones code; the meter slices it down to its result width
  localparam logic [31:0] TIMEOUT_CODE = '1;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer bringing the asynchronous chain output into clk.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) sr <= '0;
    else     sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/chain_delay_meter.sv
// Launches edges into a delay chain and reports the averaged propagation
// delay in clk cycles, or an all-ones timeout code if the chain never answers.
module chain_delay_meter
  import chain_meter_pkg::*;
#(
  parameter int INVERTING   = 1,
  parameter int SYNC_STAGES = 2,
  parameter int CW          = 12,
  parameter int MAX_CYCLES  = 4095,
  parameter int LOG_RUNS    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] count,
  output logic          chain_a,
  input  logic          chain_y
);

  localparam int                  AW       = CW + LOG_RUNS;
  localparam logic [LOG_RUNS-1:0] LAST_RUN = '1;
  localparam logic [CW-1:0]       CNT_MAX  = CW'(MAX_CYCLES);
  localparam logic                INV      = (INVERTING != 0);

  state_t              state, next_state;
  logic [CW-1:0]       cnt;
  logic [AW-1:0]       acc;
  logic [LOG_RUNS-1:0] run_idx;
  logic                y_s;
  logic                match;
  logic                at_max;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (chain_y),
    .q   (y_s)
  );

  // Chain has settled to the value implied by the current drive
  assign match  = (y_s == (chain_a ^ INV));
  assign at_max = (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SETTLE;
      SETTLE: begin
        if (match)       next_state = LAUNCH;
        else if (at_max) next_state = FAIL;
      end
      LAUNCH:  next_state = MEASURE;
      MEASURE: begin
        if (match)       next_state = (run_idx == LAST_RUN) ? DONE : LAUNCH;
        else if (at_max) next_state = FAIL;
      end
      DONE:    next_state = IDLE;
      FAIL:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // In MEASURE, cnt equals the edges elapsed since the launch edge, so the
  // value accumulated at the first match is the run's edge count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      acc     <= '0;
      run_idx <= '0;
      chain_a <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
      count   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            acc     <= '0;
            run_idx <= '0;
            timeout <= 1'b0;
            cnt     <= '0;
          end
        end
        SETTLE: begin
          if (!match && !at_max) cnt <= cnt + 1'b1;
        end
        LAUNCH: begin
          chain_a <= ~chain_a;
          cnt     <= '0;
        end
        MEASURE: begin
          if (match) begin
            acc <= acc + AW'(cnt);
            if (run_idx != LAST_RUN) run_idx <= run_idx + 1'b1;
          end else if (!at_max) begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          count <= acc[AW-1:LOG_RUNS];
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        FAIL: begin
          count   <= TIMEOUT_CODE[CW-1:0];
          timeout <= 1'b1;
          done    <= 1'b1;
          busy    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chain_delay_meter.sv
// Scoreboard bench: a behavioural delay-chain model drives chain_y and a
// monitor checks every done pulse against queued expectations.
module tb_chain_delay_meter;

  localparam int   CW       = 12;
  localparam int   LOG_RUNS = 2;
  localparam int   SYNC     = 2;
  localparam int   MAXC     = 4095;
  localparam bit   INVB     = 1'b1;
  localparam int   RUNS     = 1 << LOG_RUNS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, timeout, chain_a, chain_y;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  chain_delay_meter #(
    .INVERTING   (1),
    .SYNC_STAGES (SYNC),
    .CW          (CW),
    .MAX_CYCLES  (MAXC),
    .LOG_RUNS    (LOG_RUNS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .timeout (timeout),
    .count   (count),
    .chain_a (chain_a),
    .chain_y (chain_y)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [CW-1:0] cnt;
    logic          to;
    logic          a;
  } exp_t;
  exp_t exp_q[$];

  // Delay chain model: output follows the input after a per-direction delay
  typedef struct {
    int   due;
    logic val;
  } ev_t;
  ev_t  ev_q[$];
  int   cyc = 0;
  int   d_rise = 5;
  int   d_fall = 5;
  logic prev_a = 1'b0;
  logic model_y = 1'b1;
  logic force_en = 1'b0;
  logic force_val = 1'b0;

  assign chain_y = force_en ? force_val : model_y;

  always @(posedge clk) begin
    ev_t e;
    #1;
    cyc++;
    if (chain_a !== prev_a) begin
      e.due = cyc + (chain_a ? d_rise : d_fall);
      e.val = chain_a ^ INVB;
      ev_q.push_back(e);
      prev_a = chain_a;
    end
    while (ev_q.size() > 0 && ev_q[0].due <= cyc) begin
      model_y = ev_q[0].val;
      void'(ev_q.pop_front());
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: each run reads its launch-direction delay plus the synchronizer depth
  function automatic logic [CW-1:0] expectCount(input logic a0, input int dr, input int df);
    int   sum;
    logic a;
    sum = 0;
    a = a0;
    for (int i = 0; i < RUNS; i++) begin
      sum += ((a == 1'b0) ? dr : df) + SYNC;
      a = ~a;
    end
    return CW'(sum / RUNS);
  endfunction

  task automatic applyStimulus(input logic [CW-1:0] c, input logic to, input logic a);
    exp_t e;
    e.cnt = c;
    e.to  = to;
    e.a   = a;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) return;
    end
    checkOutput("done_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic waitChainA(input logic v, input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (chain_a === v) return;
    end
    checkOutput("chain_a_wait_expired", 32'(chain_a), 32'(v));
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      checkOutput("done_single_cycle", 32'(done_prev), 32'd0);
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("count", 32'(count), 32'(e.cnt));
        checkOutput("timeout", 32'(timeout), 32'(e.to));
        checkOutput("chain_a_at_done", 32'(chain_a), 32'(e.a));
        checkOutput("busy_at_done", 32'(busy), 32'd0);
      end
    end
    done_prev = done;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_watchdog: actual=expired required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int hold;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_chain_a", 32'(chain_a), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_timeout", 32'(timeout), 32'd0);
    checkOutput("reset_count", 32'(count), 32'd0);
    repeat (5) @(negedge clk);

    $display("[TB] symmetric chain D=5");
    d_rise = 5; d_fall = 5;
    applyStimulus(expectCount(chain_a, 5, 5), 1'b0, chain_a);
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    waitDone(500);
    repeat (5) @(negedge clk);

    $display("[TB] asymmetric chain rise=4 fall=6");
    d_rise = 4; d_fall = 6;
    applyStimulus(expectCount(chain_a, 4, 6), 1'b0, chain_a);
    waitDone(500);
    repeat (5) @(negedge clk);

    $display("[TB] stale chain held 10 cycles, D=3");
    d_rise = 3; d_fall = 3;
    force_val = chain_a;
    force_en = 1'b1;
    applyStimulus(expectCount(chain_a, 3, 3), 1'b0, chain_a);
    repeat (10) @(negedge clk);
    force_en = 1'b0;
    waitDone(500);
    repeat (5) @(negedge clk);

    $display("[TB] chain output stuck low after first launch");
    d_rise = 5; d_fall = 5;
    applyStimulus(CW'(MAXC), 1'b1, chain_a);
    waitChainA(1'b1, 100);
    force_val = 1'b0;
    force_en = 1'b1;
    waitDone(6000);
    @(negedge clk);
    checkOutput("timeout_done_width", 32'(done), 32'd0);
    force_en = 1'b0;
    repeat (20) @(negedge clk);

    $display("[TB] reset during second run");
    applyStimulus(expectCount(chain_a, 5, 5), 1'b0, chain_a);
    waitChainA(1'b1, 100);
    waitChainA(1'b0, 100);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    checkOutput("midreset_chain_a", 32'(chain_a), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_done", 32'(done), 32'd0);
    checkOutput("midreset_timeout", 32'(timeout), 32'd0);
    checkOutput("midreset_count", 32'(count), 32'd0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    applyStimulus(expectCount(chain_a, 5, 5), 1'b0, chain_a);
    waitDone(500);
    repeat (5) @(negedge clk);

    $display("[TB] start held through two back-to-back measurements");
    begin
      exp_t e;
      e.cnt = expectCount(chain_a, 5, 5);
      e.to  = 1'b0;
      e.a   = chain_a;
      exp_q.push_back(e);
      exp_q.push_back(e);
    end
    start = 1'b1;
    waitDone(500);
    waitDone(500);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("idle_after_held_start", 32'(busy), 32'd0);

    $display("[TB] start pulses while busy are ignored");
    applyStimulus(expectCount(chain_a, 5, 5), 1'b0, chain_a);
    for (int i = 0; i < 3; i++) begin
      repeat (2) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    waitDone(500);
    repeat (30) @(negedge clk);
    checkOutput("idle_after_busy_pulses", 32'(busy), 32'd0);

    $display("[TB] randomized delays and settle waits");
    for (int n = 0; n < 8; n++) begin
      d_rise = int'($urandom_range(1, 10));
      d_fall = int'($urandom_range(1, 10));
      hold = int'($urandom_range(0, 15));
      if (hold > 0) begin
        force_val = chain_a;
        force_en = 1'b1;
      end
      applyStimulus(expectCount(chain_a, d_rise, d_fall), 1'b0, chain_a);
      repeat (hold) @(negedge clk);
      force_en = 1'b0;
      waitDone(500);
      repeat (int'($urandom_range(1, 5))) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
